// File: rtl/scan_averager_pkg.sv
// Shared types and helpers for the round-robin channel scanner/averager.
package scan_averager_pkg;

    localparam int unsigned STATE_W = 2;

    // Scan controller states.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    // Accumulator width: sample width plus headroom for 2^log2_avg samples.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned log2_avg);
        return width + log2_avg;
    endfunction

endpackage

// File: rtl/scan_averager_if.sv
// Averaged-result valid/ready channel toward the capture logic.
interface scan_averager_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SEL_WIDTH = 2
);
    logic [WIDTH-1:0]     avg_data;
    logic [SEL_WIDTH-1:0] avg_chan;
    logic                 avg_valid;
    logic                 avg_ready;

    modport master (output avg_data, output avg_chan, output avg_valid, input avg_ready);
    modport slave  (input avg_data, input avg_chan, input avg_valid, output avg_ready);
endinterface

// File: rtl/scan_next_chan.sv
// Combinational round-robin picker: next set mask bit above cur, wrapping to the lowest.
module scan_next_chan
    import scan_averager_pkg::*;
#(
    parameter int unsigned N_INPUTS  = 3,
    parameter int unsigned SEL_WIDTH = 2
) (
    input  logic [N_INPUTS-1:0]  mask,
    input  logic [SEL_WIDTH-1:0] cur,
    output logic [SEL_WIDTH-1:0] next_c,
    output logic                 none_c
);

    logic [SEL_WIDTH-1:0] lowest;
    logic [SEL_WIDTH-1:0] above;
    logic                 found_above;

    // Scan downward so the last hit is the lowest index in each category.
    always_comb begin
        lowest      = '0;
        above       = '0;
        found_above = 1'b0;
        for (int i = int'(N_INPUTS) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = SEL_WIDTH'(i);
                if (SEL_WIDTH'(i) > cur) begin
                    above       = SEL_WIDTH'(i);
                    found_above = 1'b1;
                end
            end
        end
        next_c = found_above ? above : lowest;
        none_c = (mask == '0);
    end

endmodule

// File: rtl/scan_averager.sv
// Round-robin scanner/averager around the registered N-to-1 interconnect.
// Optional build macro: SCAN_AVERAGER_ROUND_EN selects round-half-up with
// saturation for the average; without it the average is truncated.
module scan_averager
    import scan_averager_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned N_INPUTS  = 3,
    parameter int unsigned SEL_WIDTH = 2,
    parameter int unsigned LOG2_AVG  = 2,
    parameter int unsigned SETTLE    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_INPUTS-1:0]  chan_mask,
    input  logic [WIDTH-1:0]     in_data,
    output logic [SEL_WIDTH-1:0] sel,
    scan_averager_if.master      avg
);

    localparam int unsigned ACC_W   = acc_width(WIDTH, LOG2_AVG);
    localparam int unsigned AVG_CNT = 32'd1 << LOG2_AVG;
    localparam int unsigned CNT_MAX = (SETTLE > AVG_CNT) ? SETTLE : AVG_CNT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [ACC_W-1:0]     acc, acc_nxt, acc_sum;
    logic [SEL_WIDTH-1:0] sel_nxt;
    logic [WIDTH-1:0]     data_nxt;
    logic [SEL_WIDTH-1:0] chan_nxt;
    logic                 valid_nxt;
    logic [WIDTH-1:0]     avg_word;

    logic [SEL_WIDTH-1:0] pick_cur, pick_next;
    logic                 pick_none;

    // From IDLE the search starts above the top channel so it lands on the lowest set bit.
    assign pick_cur = (state == ST_IDLE) ? SEL_WIDTH'(N_INPUTS - 1) : sel;

    scan_next_chan #(
        .N_INPUTS  (N_INPUTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_next_chan (
        .mask   (chan_mask),
        .cur    (pick_cur),
        .next_c (pick_next),
        .none_c (pick_none)
    );

    assign acc_sum = acc + ACC_W'(in_data);

`ifdef SCAN_AVERAGER_ROUND_EN
    localparam int unsigned RND_W = ACC_W + 1;
    localparam int unsigned HALF  = 32'd1 << (LOG2_AVG - 1);

    logic [RND_W-1:0] acc_rnd;
    logic [RND_W-1:0] acc_shr;

    // Round half up, then clamp to the sample range.
    always_comb begin
        acc_rnd  = {1'b0, acc_sum} + RND_W'(HALF);
        acc_shr  = acc_rnd >> LOG2_AVG;
        avg_word = (|acc_shr[RND_W-1:WIDTH]) ? '1 : acc_shr[WIDTH-1:0];
    end
`else
    // Plain truncating divide by the sample count.
    assign avg_word = acc_sum[ACC_W-1:LOG2_AVG];
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        sel_nxt   = sel;
        data_nxt  = avg.avg_data;
        chan_nxt  = avg.avg_chan;
        valid_nxt = avg.avg_valid;

        case (state)
            ST_IDLE: begin
                if (en && !pick_none) begin
                    sel_nxt   = pick_next;
                    cnt_nxt   = '0;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!en) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_W'(SETTLE - 1)) begin
                    cnt_nxt   = '0;
                    acc_nxt   = '0;
                    state_nxt = ST_ACCUM;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_ACCUM: begin
                if (!en) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    acc_nxt = acc_sum;
                    if (cnt == CNT_W'(AVG_CNT - 1)) begin
                        data_nxt  = avg_word;
                        chan_nxt  = sel;
                        valid_nxt = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_OUTPUT;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_OUTPUT: begin
                if (avg.avg_valid && avg.avg_ready) begin
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                    if (!en || pick_none) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        sel_nxt   = pick_next;
                        state_nxt = ST_SETTLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            acc           <= '0;
            sel           <= '0;
            avg.avg_data  <= '0;
            avg.avg_chan  <= '0;
            avg.avg_valid <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            acc           <= acc_nxt;
            sel           <= sel_nxt;
            avg.avg_data  <= data_nxt;
            avg.avg_chan  <= chan_nxt;
            avg.avg_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_scan_averager.sv
// Directed scoreboard bench for scan_averager with a registered-mux interconnect model.
module tb_scan_averager;

    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] chan_mask = 3'b000;
    logic [7:0] in_data = 8'h00;
    logic [1:0] sel;
    logic [7:0] ch_val [3];

    int n_assert = 0;
    int n_fail   = 0;
    int n_seen   = 0;
    int cyc      = 0;
    exp_t sb[$];
    int   hs_cyc[$];

    scan_averager_if #(.WIDTH(8), .SEL_WIDTH(2)) avg_if ();

    scan_averager #(
        .WIDTH     (8),
        .N_INPUTS  (3),
        .SEL_WIDTH (2),
        .LOG2_AVG  (2),
        .SETTLE    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .chan_mask (chan_mask),
        .in_data   (in_data),
        .sel       (sel),
        .avg       (avg_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered interconnect: out follows the selected channel one cycle later.
    always @(posedge clk) in_data <= (sel < 2'd3) ? ch_val[sel] : 8'h00;

    function automatic logic [7:0] avg_of(input int sum);
        int r;
`ifdef SCAN_AVERAGER_ROUND_EN
        r = (sum + 2) >> 2;
        if (r > 255) r = 255;
`else
        r = sum >> 2;
`endif
        return 8'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [1:0] ch, input int sum);
        exp_t e;
        e.chan = ch;
        e.data = avg_of(sum);
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let k results through, dropping en in the cycle the last one is presented.
    task automatic run_until(input int k, input int budget, input string tag);
        int base;
        bit hit;
        base = n_seen;
        hit  = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            step();
            if (avg_if.avg_valid && n_seen == base + k - 1) begin
                en  = 1'b0;
                hit = 1'b1;
            end
        end
        step();
        check({tag, "_count"}, n_seen, base + k);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        for (int i = 0; i < budget && !avg_if.avg_valid; i++) step();
        check(tag, avg_if.avg_valid, 1);
    endtask

    // Scoreboard: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && avg_if.avg_valid && avg_if.avg_ready) begin
            n_seen++;
            hs_cyc.push_back(cyc);
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected observed chan=%0d data=%0h expected none",
                       avg_if.avg_chan, avg_if.avg_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("res_chan", avg_if.avg_chan, e.chan);
                check("res_data", avg_if.avg_data, e.data);
            end
        end
    end

    initial begin
        int c_en;
        int base;
        ch_val[0] = 8'h00;
        ch_val[1] = 8'hFF;
        ch_val[2] = 8'h10;
        avg_if.avg_ready = 1'b1;

        // Reset values.
        repeat (3) step();
        check("rst_sel", sel, 0);
        check("rst_data", avg_if.avg_data, 0);
        check("rst_chan", avg_if.avg_chan, 0);
        check("rst_valid", avg_if.avg_valid, 0);
        rst = 1'b0;
        repeat (2) step();

        // Full mask round robin, ready always high.
        hs_cyc.delete();
        chan_mask = 3'b111;
        push(2'd0, 4 * 8'h00);
        push(2'd1, 4 * 8'hFF);
        push(2'd2, 4 * 8'h10);
        push(2'd0, 4 * 8'h00);
        en   = 1'b1;
        c_en = cyc;
        run_until(4, 60, "rr111");
        if (hs_cyc.size() == 4) begin
            check("first_latency", hs_cyc[0] - c_en, 7);
            for (int i = 1; i < 4; i++) check("period", hs_cyc[i] - hs_cyc[i-1], 7);
        end else begin
            check("hs_count", hs_cyc.size(), 4);
        end
        repeat (3) step();

        // Sparse mask skips channel 1.
        chan_mask = 3'b101;
        push(2'd0, 4 * 8'h00);
        push(2'd2, 4 * 8'h10);
        push(2'd0, 4 * 8'h00);
        push(2'd2, 4 * 8'h10);
        en = 1'b1;
        run_until(4, 60, "rr101");
        repeat (3) step();

        // Backpressure: result held stable while ready is low.
        avg_if.avg_ready = 1'b0;
        chan_mask = 3'b110;
        en = 1'b1;
        wait_valid(30, "bp_valid");
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_hold_valid", avg_if.avg_valid, 1);
            check("bp_hold_data", avg_if.avg_data, avg_of(4 * 8'hFF));
            check("bp_hold_sel", sel, 1);
        end
        push(2'd1, 4 * 8'hFF);
        base = n_seen;
        avg_if.avg_ready = 1'b1;
        step();
        check("bp_accepted", n_seen, base + 1);
        check("bp_sel_adv", sel, 2);
        check("bp_valid_clr", avg_if.avg_valid, 0);
        en = 1'b0;
        repeat (3) step();

        // Samples 1,2,2,2 on channel 0.
        chan_mask = 3'b001;
        ch_val[0] = 8'h01;
        push(2'd0, 1 + 2 + 2 + 2);
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ch_val[0] = 8'h02;
        run_until(1, 30, "trunc");
        ch_val[0] = 8'h00;
        repeat (3) step();

        // en dropped mid-accumulation, then restart at lowest mask bit.
        chan_mask = 3'b110;
        en = 1'b1;
        base = n_seen;
        repeat (4) @(posedge clk);
        #1;
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("abort_valid", avg_if.avg_valid, 0);
            check("abort_sel", sel, 1);
        end
        check("abort_no_result", n_seen, base);
        chan_mask = 3'b111;
        push(2'd0, 4 * 8'h00);
        en = 1'b1;
        step();
        check("restart_sel", sel, 0);
        run_until(1, 30, "restart");
        repeat (3) step();

        // Reset while a result is pending.
        avg_if.avg_ready = 1'b0;
        chan_mask = 3'b100;
        en = 1'b1;
        wait_valid(30, "rst_pend_valid");
        check("rst_pend_data", avg_if.avg_data, avg_of(4 * 8'h10));
        rst = 1'b1;
        step();
        check("rst_out_valid", avg_if.avg_valid, 0);
        check("rst_out_sel", sel, 0);
        check("rst_out_data", avg_if.avg_data, 0);
        check("rst_out_chan", avg_if.avg_chan, 0);
        rst = 1'b0;
        en = 1'b0;
        avg_if.avg_ready = 1'b1;
        repeat (10) step();
        check("post_rst_idle_valid", avg_if.avg_valid, 0);
        check("post_rst_idle_sel", sel, 0);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_averager.md
# scan_averager

Round-robin channel scanner and averager wrapped around the registered N-to-1 channel interconnect. Drives the interconnect's `sel`, discards the post-switch settling samples on its output, and accumulates 2^LOG2_AVG samples per channel. Emits one averaged word per channel, tagged with the channel index, over a valid/ready handshake toward the capture/BRAM logic.

## Interface
- WIDTH, 8, sample width (unsigned)
- N_INPUTS, 3, number of interconnect channels
- SEL_WIDTH, 2, channel index width; 2^SEL_WIDTH >= N_INPUTS
- LOG2_AVG, 2, log2 of samples averaged per channel; >= 1
- SETTLE, 2, samples discarded after each `sel` change; >= 1 (covers interconnect register latency)

- clk  input  1  sole clock
- rst  input  1  synchronous, active-high reset
- en  input  1  scan enable
- chan_mask  input  N_INPUTS  bit i = 1 includes channel i in the scan
- in_data  input  WIDTH  interconnect `out`
- sel  output  SEL_WIDTH  interconnect select, registered
- avg_data  output  WIDTH  averaged sample
- avg_chan  output  SEL_WIDTH  channel index of `avg_data`
- avg_valid  output  1  result valid
- avg_ready  input  1  consumer accepts result

## Operation
- Reset values: `sel`=0, `avg_data`=0, `avg_chan`=0, `avg_valid`=0; state IDLE; counters and accumulator 0.
- States: IDLE, SETTLE, ACCUM, OUTPUT.
- IDLE: if `en` and `chan_mask`!=0, load `sel` with the lowest set mask bit and go to SETTLE. Otherwise stay; `sel` holds its last value.
- SETTLE: count SETTLE cycles, ignoring `in_data`, then go to ACCUM with the accumulator cleared.
- ACCUM: add `in_data` every cycle for 2^LOG2_AVG cycles. On the last sample, register `avg_data` = acc >> LOG2_AVG (truncation), `avg_chan` = `sel`, set `avg_valid`, and go to OUTPUT.
- Accumulator width: WIDTH+LOG2_AVG bits, unsigned, no overflow possible.
- OUTPUT: hold `avg_valid`, `avg_data`, `avg_chan` and `sel` stable until `avg_valid && avg_ready`. On the handshake:
  - clear `avg_valid`;
  - if `en`=0 or `chan_mask`=0, go to IDLE;
  - else load `sel` with the next set mask bit above the current channel, wrapping to the lowest set bit, and go to SETTLE. With a single set bit, the same channel is reselected and SETTLE is still applied.
- Mask bits >= N_INPUTS do not exist. `chan_mask` is sampled only at channel advance; changes mid-channel take effect at the next advance.
- `en` falling in SETTLE or ACCUM: abandon the channel, go to IDLE next cycle, produce no result.
- `en` falling in OUTPUT: the pending result is still held until accepted, then go to IDLE.
- `rst` in any state: all outputs and state to reset values at the next edge; any pending result is dropped.

## Timing
- Cycle 0 is the first cycle with the new `sel` visible (state SETTLE). The interconnect output is valid from cycle 1.
- Samples are accumulated in cycles SETTLE … SETTLE+2^LOG2_AVG−1.
- `avg_valid` is high from cycle SETTLE+2^LOG2_AVG.
- With `avg_ready`=1, the handshake occurs in that same cycle, the next `sel` appears the following cycle, and the per-channel period is SETTLE+2^LOG2_AVG+1 cycles.
- IDLE→SETTLE: the `sel` update is visible one cycle after `en` is sampled high.

## Configuration
- SCAN_AVERAGER_ROUND_EN defined: `avg_data` = min((acc + 2^(LOG2_AVG−1)) >> LOG2_AVG, 2^WIDTH−1), i.e. round-half-up with saturation. The adder is one bit wider than the accumulator.
- Undefined: plain truncation as above; no rounding adder is built.

## Structure
- `scan_averager_pkg`: state enum (IDLE, SETTLE, ACCUM, OUTPUT) and an accumulator-width constant function (WIDTH+LOG2_AVG).
- Sub-module `scan_next_chan`: combinational round-robin picker. Inputs are the mask and current index; outputs are the next set index above current (wrapping) and a `none` flag. It is reused for both the IDLE start (current index forced to N_INPUTS−1) and the OUTPUT advance.

## Test plan
Defaults: WIDTH=8, N_INPUTS=3, LOG2_AVG=2, SETTLE=2. The bench drives `in_data` from a registered mux model with ch0=0x00, ch1=0xFF, ch2=0x10.

- mask=3'b111, en=1, ready=1 → results (0,0x00), (1,0xFF), (2,0x10), (0,0x00); `avg_valid` pulses every 7 cycles; first valid 7 cycles after `en`.
- mask=3'b101 → `sel` sequence 0,2,0,2; `avg_chan` never 1.
- Result pending with ready=0 for 20 cycles → `avg_valid`, `avg_data`, `sel` stable throughout; ready=1 → handshake, then `sel` advances next cycle.
- ch0 samples 1,2,2,2 → 0x01 truncated; 0x02 with SCAN_AVERAGER_ROUND_EN. ch1 all 0xFF with rounding → 0xFF (saturated).
- en dropped in the 2nd ACCUM cycle → no `avg_valid`, IDLE next cycle, `sel` unchanged; en re-raised → scan restarts at lowest mask bit.
- rst asserted during OUTPUT → next cycle `avg_valid`=0, `sel`=0, `avg_data`=0, state IDLE.
